// File: rtl/demux_deserializer.sv
// Two-channel serial-to-parallel deserializer fed by a 1:2 demux select.
// Each channel assembles MSB-first WIDTH-bit words into a valid/ready holding register with sticky overflow.
module demux_deserializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i,
    input  logic             s,
    input  logic             in_valid,
    output logic [WIDTH-1:0] y0_data,
    output logic             y0_valid,
    input  logic             y0_ready,
    output logic [WIDTH-1:0] y1_data,
    output logic             y1_valid,
    input  logic             y1_ready,
    output logic [1:0]       ovf,
    input  logic             ovf_clr
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] sh_q   [2];
    logic [WIDTH-1:0] sh_d   [2];
    logic [CW-1:0]    cnt_q  [2];
    logic [CW-1:0]    cnt_d  [2];
    logic [WIDTH-1:0] data_q [2];
    logic [WIDTH-1:0] data_d [2];
    logic [1:0]       valid_q;
    logic [1:0]       valid_d;
    logic [1:0]       ovf_q;
    logic [1:0]       ovf_d;
    logic [1:0]       ready;
    logic [WIDTH-1:0] word;

    assign ready = {y1_ready, y0_ready};

    always_comb begin
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = valid_q;
        word    = '0;
        // Clear is applied first so a same-cycle overflow below takes priority.
        ovf_d   = ovf_clr ? 2'b00 : ovf_q;
        for (int unsigned ch = 0; ch < 2; ch++) begin
            if (valid_q[ch] && ready[ch]) begin
                valid_d[ch] = 1'b0;
            end
            if (in_valid && (s == ch[0])) begin
                word = {sh_q[ch][WIDTH-2:0], i};
                if (cnt_q[ch] == CNT_LAST) begin
                    cnt_d[ch] = '0;
                    sh_d[ch]  = '0;
                    if (!valid_q[ch] || ready[ch]) begin
                        data_d[ch]  = word;
                        valid_d[ch] = 1'b1;
                    end else begin
                        ovf_d[ch] = 1'b1;
                    end
                end else begin
                    cnt_d[ch] = cnt_q[ch] + CW'(1);
                    sh_d[ch]  = word;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned ch = 0; ch < 2; ch++) begin
                sh_q[ch]   <= '0;
                cnt_q[ch]  <= '0;
                data_q[ch] <= '0;
            end
            valid_q <= '0;
            ovf_q   <= '0;
        end else begin
            for (int unsigned ch = 0; ch < 2; ch++) begin
                sh_q[ch]   <= sh_d[ch];
                cnt_q[ch]  <= cnt_d[ch];
                data_q[ch] <= data_d[ch];
            end
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign y0_data  = data_q[0];
    assign y1_data  = data_q[1];
    assign y0_valid = valid_q[0];
    assign y1_valid = valid_q[1];
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_demux_deserializer.sv
// Self-checking bench for demux_deserializer: a vector table, directed corner sequences,
// and randomized traffic compared against a word-level reference model built from bit queues.
module tb_demux_deserializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         i;
    logic         s;
    logic         in_valid;
    logic [W-1:0] y0_data;
    logic         y0_valid;
    logic         y0_ready;
    logic [W-1:0] y1_data;
    logic         y1_valid;
    logic         y1_ready;
    logic [1:0]   ovf;
    logic         ovf_clr;

    demux_deserializer #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .i        (i),
        .s        (s),
        .in_valid (in_valid),
        .y0_data  (y0_data),
        .y0_valid (y0_valid),
        .y0_ready (y0_ready),
        .y1_data  (y1_data),
        .y1_valid (y1_valid),
        .y1_ready (y1_ready),
        .ovf      (ovf),
        .ovf_clr  (ovf_clr)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: bits are queued per channel, a word is formed once WIDTH bits have arrived.
    bit           mq0[$];
    bit           mq1[$];
    logic [W-1:0] m_data [2];
    logic [1:0]   m_valid;
    logic [1:0]   m_ovf;

    typedef struct {
        logic        iv;
        logic        ss;
        logic        ii;
        logic        r0;
        logic        r1;
        logic        clr;
        logic [19:0] exp;   // {y0_valid, y0_data, y1_valid, y1_data, ovf}
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] pack_bits(input bit q[$]);
        logic [W-1:0] w = '0;
        foreach (q[k]) w = W'((w << 1) | W'(q[k]));
        return w;
    endfunction

    task automatic model_reset();
        mq0.delete();
        mq1.delete();
        m_data[0] = '0;
        m_data[1] = '0;
        m_valid   = '0;
        m_ovf     = '0;
    endtask

    task automatic model_step();
        logic [1:0]   rdy;
        logic [1:0]   nv;
        logic [1:0]   no;
        logic [W-1:0] w;
        bit           done;
        int           ch;
        rdy  = {y1_ready, y0_ready};
        nv   = m_valid & ~rdy;
        no   = ovf_clr ? 2'b00 : m_ovf;
        done = 0;
        w    = '0;
        ch   = int'(s);
        if (in_valid) begin
            if (ch == 0) begin
                mq0.push_back(i);
                if (mq0.size() == W) begin w = pack_bits(mq0); mq0.delete(); done = 1; end
            end else begin
                mq1.push_back(i);
                if (mq1.size() == W) begin w = pack_bits(mq1); mq1.delete(); done = 1; end
            end
            if (done) begin
                if (!m_valid[ch] || rdy[ch]) begin
                    m_data[ch] = w;
                    nv[ch]     = 1'b1;
                end else begin
                    no[ch] = 1'b1;
                end
            end
        end
        m_valid = nv;
        m_ovf   = no;
    endtask

    task automatic compare_model();
        check("y0_valid", 32'(y0_valid), 32'(m_valid[0]));
        check("y1_valid", 32'(y1_valid), 32'(m_valid[1]));
        check("ovf", 32'(ovf), 32'(m_ovf));
        if (m_valid[0]) check("y0_data", 32'(y0_data), 32'(m_data[0]));
        if (m_valid[1]) check("y1_data", 32'(y1_data), 32'(m_data[1]));
    endtask

    task automatic step(input logic iv, input logic ss, input logic ii,
                        input logic r0, input logic r1, input logic clr);
        in_valid = iv;
        s        = ss;
        i        = ii;
        y0_ready = r0;
        y1_ready = r1;
        ovf_clr  = clr;
        model_step();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic send_word(input logic ch, input logic [W-1:0] w,
                             input logic r0, input logic r1);
        for (int k = W - 1; k >= 0; k--) step(1'b1, ch, w[k], r0, r1, 1'b0);
    endtask

    // Asynchronous reset pulse between clock edges; outputs must clear without waiting for a clock.
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        check({tag, "_rst_out"}, {y0_valid, y1_valid, ovf, y0_data, y1_data}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        rst      = 1'b1;
        i        = 1'b0;
        s        = 1'b0;
        in_valid = 1'b0;
        y0_ready = 1'b0;
        y1_ready = 1'b0;
        ovf_clr  = 1'b0;
        model_reset();
        #1;
        check("reset_state", {y0_valid, y1_valid, ovf, y0_data, y1_data}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Build some state, then reset mid-operation.
        send_word(1'b1, 8'h77, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        async_reset("midop");

        // Vector table: A5 on channel 0, held under back-pressure, then drained.
        begin
            logic [W-1:0] a5;
            a5 = 8'hA5;
            for (int k = 0; k < 8; k++) begin
                tbl[k] = '{1'b1, 1'b0, a5[7-k], 1'b0, 1'b0, 1'b0,
                           (k == 7) ? {1'b1, 8'hA5, 1'b0, 8'h00, 2'b00} : 20'h0};
            end
            tbl[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, {1'b1, 8'hA5, 1'b0, 8'h00, 2'b00}};
            tbl[9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, {1'b0, 8'hA5, 1'b0, 8'h00, 2'b00}};
        end
        foreach (tbl[k]) begin
            step(tbl[k].iv, tbl[k].ss, tbl[k].ii, tbl[k].r0, tbl[k].r1, tbl[k].clr);
            check($sformatf("tbl_row%0d", k), {12'h0, y0_valid, y0_data, y1_valid, y1_data, ovf},
                  {12'h0, tbl[k].exp});
        end

        // Interleaving: channel 0 receives all ones, channel 1 all zeros.
        for (int k = 0; k < 16; k++) step(1'b1, k[0], ~k[0], 1'b0, 1'b0, 1'b0);
        check("ilv_y0", {y0_valid, y0_data}, {1'b1, 8'hFF});
        check("ilv_y1", {y1_valid, y1_data}, {1'b1, 8'h00});
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

        // Gapped input: three idle cycles mid-word.
        begin
            logic [W-1:0] g;
            g = 8'h5A;
            for (int k = 7; k >= 3; k--) step(1'b1, 1'b0, g[k], 1'b0, 1'b0, 1'b0);
            for (int k = 0; k < 3; k++) begin
                step(1'b0, $urandom_range(0, 1), $urandom_range(0, 1), 1'b0, 1'b0, 1'b0);
                check("gap_idle", 32'(y0_valid), 32'h0);
            end
            for (int k = 2; k >= 1; k--) step(1'b1, 1'b0, g[k], 1'b0, 1'b0, 1'b0);
            check("gap_before_last", 32'(y0_valid), 32'h0);
            step(1'b1, 1'b0, g[0], 1'b0, 1'b0, 1'b0);
            check("gap_word", {y0_valid, y0_data}, {1'b1, 8'h5A});
            step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        end

        // Back-pressure overflow on channel 1.
        send_word(1'b1, 8'h3C, 1'b0, 1'b0);
        send_word(1'b1, 8'hC3, 1'b0, 1'b0);
        check("ovf_hold", {y1_valid, y1_data, ovf}, {1'b1, 8'h3C, 2'b10});
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("ovf_clr", 32'(ovf), 32'h0);
        begin
            logic [W-1:0] c;
            c = 8'hC3;
            for (int k = 7; k >= 1; k--) step(1'b1, 1'b1, c[k], 1'b0, 1'b0, 1'b0);
            step(1'b1, 1'b1, c[0], 1'b0, 1'b0, 1'b1);
            check("ovf_set_wins", {y1_data, ovf}, {8'h3C, 2'b10});
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("ovf_drain_clr", {y1_valid, ovf}, 32'h0);

        // Drain and reload in the same cycle on channel 0.
        send_word(1'b0, 8'h11, 1'b0, 1'b0);
        begin
            logic [W-1:0] r;
            r = 8'h81;
            for (int k = 7; k >= 1; k--) step(1'b1, 1'b0, r[k], 1'b0, 1'b0, 1'b0);
            check("reload_pre", {y0_valid, y0_data}, {1'b1, 8'h11});
            step(1'b1, 1'b0, r[0], 1'b1, 1'b0, 1'b0);
            check("reload", {y0_valid, y0_data, ovf[0]}, {1'b1, 8'h81, 1'b0});
        end
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Mid-word reset discards partial bits.
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        async_reset("midword");
        send_word(1'b0, 8'h12, 1'b0, 1'b0);
        check("after_reset_word", {y0_valid, y0_data}, {1'b1, 8'h12});
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 3) != 0), $urandom_range(0, 1), $urandom_range(0, 1),
                 ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 19) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
